// File: rtl/fifo_ptr_pkg.sv
// Shared definitions for the FIFO pointer controller: incrementer speed codes and occupancy helper.
package fifo_ptr_pkg;

    localparam int unsigned SPEED_SLOW   = 0;
    localparam int unsigned SPEED_MEDIUM = 1;
    localparam int unsigned SPEED_FAST   = 2;

    localparam int unsigned USAGE_W = 32;

    // Occupancy of a pointer pair of width aw+1; pointers wider than USAGE_W are not supported.
    function automatic logic [USAGE_W-1:0] usage_calc(input logic [USAGE_W-1:0] wptr,
                                                      input logic [USAGE_W-1:0] rptr,
                                                      input int unsigned        aw);
        logic [USAGE_W-1:0] mask;
        mask = ((aw + 1) >= USAGE_W) ? '1 : ((USAGE_W'(1) << (aw + 1)) - USAGE_W'(1));
        return (wptr - rptr) & mask;
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl_if.sv
// Producer/consumer handshake plus RAM address and status bundle of the FIFO pointer controller.
interface fifo_ptr_ctrl_if #(
    parameter int unsigned aw = 4
);
    logic          flush_i;
    logic          push_valid_i;
    logic          push_ready_o;
    logic          pop_valid_o;
    logic          pop_ready_i;
    logic          wr_en_o;
    logic [aw-1:0] wr_addr_o;
    logic [aw-1:0] rd_addr_o;
    logic          full_o;
    logic          empty_o;
    logic          afull_o;
    logic [aw:0]   usage_o;

    // FIFO user side: drives requests, observes status
    modport master (
        output flush_i, push_valid_i, pop_ready_i,
        input  push_ready_o, pop_valid_o, wr_en_o, wr_addr_o, rd_addr_o,
               full_o, empty_o, afull_o, usage_o
    );

    // Controller side
    modport slave (
        input  flush_i, push_valid_i, pop_ready_i,
        output push_ready_o, pop_valid_o, wr_en_o, wr_addr_o, rd_addr_o,
               full_o, empty_o, afull_o, usage_o
    );
endinterface

// File: rtl/Inc.sv
// Incrementer with selectable carry structure: ripple, Brent-Kung or Sklansky prefix.
module Inc
    import fifo_ptr_pkg::*;
#(
    parameter int unsigned width = 4,
    parameter int unsigned speed = SPEED_MEDIUM
) (
    input  logic [width-1:0] a_i,
    output logic [width-1:0] z_o
);
    localparam int W = int'(width);

    // Exclusive AND-prefix seed: bit i carries a[i-1], bit 0 is the +1
    function automatic logic [width-1:0] seed(input logic [width-1:0] a);
        logic [width-1:0] p;
        p[0] = 1'b1;
        for (int i = 1; i < W; i++) p[i] = a[i-1];
        return p;
    endfunction

    function automatic logic [width-1:0] carry_serial(input logic [width-1:0] a);
        logic [width-1:0] p;
        p = seed(a);
        for (int i = 1; i < W; i++) p[i] = p[i] & p[i-1];
        return p;
    endfunction

    function automatic logic [width-1:0] carry_bk(input logic [width-1:0] a);
        logic [width-1:0] p;
        int               top;
        p   = seed(a);
        top = 1;
        for (int d = 1; d < W; d = d * 2) begin
            top = d;
            for (int i = 2 * d - 1; i < W; i = i + 2 * d) p[i] = p[i] & p[i-d];
        end
        for (int d = top; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < W; i = i + 2 * d) p[i] = p[i] & p[i-d];
        end
        return p;
    endfunction

    function automatic logic [width-1:0] carry_sk(input logic [width-1:0] a);
        logic [width-1:0] p;
        p = seed(a);
        for (int d = 1; d < W; d = d * 2) begin
            for (int i = 0; i < W; i++) begin
                if (((i / d) % 2) == 1) p[i] = p[i] & p[(i / d) * d - 1];
            end
        end
        return p;
    endfunction

    logic [width-1:0] carry;

    // Carry network chosen by the speed parameter
    always_comb begin
        carry = '0;
        case (speed)
            SPEED_MEDIUM: carry = carry_bk(a_i);
            SPEED_FAST:   carry = carry_sk(a_i);
            default:      carry = carry_serial(a_i);
        endcase
    end

    assign z_o = a_i ^ carry;

endmodule

// File: rtl/fifo_ptr_reg.sv
// One wrap-bit pointer: incrementer plus enable register with async and sync clear.
module fifo_ptr_reg
    import fifo_ptr_pkg::*;
#(
    parameter int unsigned aw    = 4,
    parameter int unsigned speed = SPEED_MEDIUM
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        en_i,
    output logic [aw:0] ptr_o
);
    localparam int unsigned PTR_W = aw + 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] ptr_inc;

    Inc #(.width(PTR_W), .speed(speed)) u_inc (
        .a_i (ptr_q),
        .z_o (ptr_inc)
    );

    // Next pointer: clear wins over advance
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (en_i) begin
            ptr_d = ptr_inc;
        end
    end

    // Pointer register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointer controller for a 2**aw-entry FIFO with external storage.
module fifo_ptr_ctrl
    import fifo_ptr_pkg::*;
#(
    parameter int unsigned aw       = 4,
    parameter int unsigned speed    = SPEED_MEDIUM,
    parameter int unsigned afull_th = (2 ** aw) - 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    fifo_ptr_ctrl_if.slave bus
);
    localparam int unsigned PTR_W = aw + 1;

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] usage;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    fifo_ptr_reg #(.aw(aw), .speed(speed)) u_wr_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (bus.flush_i),
        .en_i   (push),
        .ptr_o  (wptr)
    );

    fifo_ptr_reg #(.aw(aw), .speed(speed)) u_rd_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (bus.flush_i),
        .en_i   (pop),
        .ptr_o  (rptr)
    );

    // Flags and occupancy decoded from the registered pointers; handshakes gated by them
    always_comb begin
        empty = (wptr == rptr);
        full  = (wptr[aw] != rptr[aw]) && (wptr[aw-1:0] == rptr[aw-1:0]);
        usage = PTR_W'(usage_calc(USAGE_W'(wptr), USAGE_W'(rptr), aw));
        push  = bus.push_valid_i & ~full;
        pop   = bus.pop_ready_i & ~empty;
    end

    assign bus.push_ready_o = ~full;
    assign bus.pop_valid_o  = ~empty;
    assign bus.wr_en_o      = push & ~bus.flush_i;
    assign bus.wr_addr_o    = wptr[aw-1:0];
    assign bus.rd_addr_o    = rptr[aw-1:0];
    assign bus.full_o       = full;
    assign bus.empty_o      = empty;
    assign bus.afull_o      = (usage >= PTR_W'(afull_th));
    assign bus.usage_o      = usage;

endmodule
